// File: rtl/square_wave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : square_wave_pkg
// Purpose  : Constants shared by the square wave generator and the
//            measurement block. Keeping the unit size and period width in one
//            place means loopback units match by construction. The package
//            also holds the measurement FSM state encoding.
// Revision : 1.0  initial release
// ============================================================================
package square_wave_pkg;

    // One unit is this many clocks: 100 ns at a 10 ns clock.
    localparam int c_unit_cycles = 10;
    // Width of the on/off period fields, in units.
    localparam int c_period_w    = 4;

    // Measurement FSM state encoding.
    localparam int         c_state_w   = 2;
    localparam logic [1:0] c_st_settle = 2'd0;
    localparam logic [1:0] c_st_arm    = 2'd1;
    localparam logic [1:0] c_st_high   = 2'd2;
    localparam logic [1:0] c_st_low    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : Brings an asynchronous input into the clk domain through a
//            SYNC_STAGES flop chain. It then produces registered single-cycle
//            rise and fall strobes.
// Ports    : clk      system clock
//            reset    synchronous active-high reset
//            i_signal asynchronous input
//            o_rise   one-cycle strobe on a synchronized 0->1 transition
//            o_fall   one-cycle strobe on a synchronized 1->0 transition
// Revision : 1.0  initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_signal,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};
            r_s_d  <= w_s;
            r_rise <= w_s & ~r_s_d;
            r_fall <= ~w_s & r_s_d;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/square_wave_meas.sv
`default_nettype none
// ============================================================================
// Module   : square_wave_meas
// Purpose  : Measures the high and low phase lengths of an asynchronous
//            square wave in units of UNIT_CYCLES clocks, rounded to the
//            nearest unit and saturating at 2^W-1. It publishes one matched
//            on/off pair per complete period (rise, fall, rise).
// Ports    : clk         system clock
//            reset       synchronous active-high reset
//            signal      asynchronous square wave under measurement
//            on_period   last measured high-phase length (units)
//            off_period  last measured low-phase length (units)
//            done        one-cycle pulse when the period outputs update
//            ovf         with done: a phase of that period saturated
//            stuck       current phase has saturated without an edge
// Revision : 1.0  initial release
// ============================================================================
module square_wave_meas
    import square_wave_pkg::*;
#(
    parameter int UNIT_CYCLES = c_unit_cycles,
    parameter int W           = c_period_w,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         signal,
    output logic [W-1:0] on_period,
    output logic [W-1:0] off_period,
    output logic         done,
    output logic         ovf,
    output logic         stuck
);

    localparam int            c_pw          = $clog2(UNIT_CYCLES);
    localparam int            c_sw          = $clog2(SYNC_STAGES + 2);
    localparam logic [c_pw-1:0] c_presc_half = c_pw'(UNIT_CYCLES / 2);
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(UNIT_CYCLES - 1);
    localparam logic [c_sw-1:0] c_settle_end = c_sw'(SYNC_STAGES + 1);
    localparam logic [W-1:0]  c_units_max   = '1;

    logic w_rise;
    logic w_fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk      (clk),
        .reset    (reset),
        .i_signal (signal),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;
    logic [c_sw-1:0]      r_settle_cnt;
    logic [c_pw-1:0]      r_presc;
    logic [W-1:0]         r_units;
    logic [W-1:0]         r_on_hold;
    logic [W-1:0]         r_on_period;
    logic [W-1:0]         r_off_period;
    logic                 r_done;
    logic                 r_ovf;
    logic                 r_stuck;

    logic                 w_clear;
    logic                 w_latch_on;
    logic                 w_publish;
    logic                 w_tick;
    logic [W-1:0]         w_units_inc;

    // The prescaler starts at half a unit after each edge, so each unit
    // boundary is crossed at the midpoint. The count including the current
    // cycle is therefore the phase length rounded to the nearest unit.
    assign w_tick      = (r_presc == c_presc_last);
    assign w_units_inc = (w_tick && (r_units != c_units_max)) ? r_units + W'(1) : r_units;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_settle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_latch_on   = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            // The counters stay cleared here, so the unit counter begins a
            // fresh phase on entry to ARM. An edge produced by the synchronizer
            // leaving its reset value is dropped here.
            c_st_settle: begin
                w_clear = 1'b1;
                if (r_settle_cnt == c_settle_end) begin
                    w_state_next = c_st_arm;
                end
            end
            c_st_arm: begin
                if (w_rise) begin
                    w_clear      = 1'b1;
                    w_state_next = c_st_high;
                end
            end
            c_st_high: begin
                if (w_fall) begin
                    w_latch_on   = 1'b1;
                    w_clear      = 1'b1;
                    w_state_next = c_st_low;
                end
            end
            c_st_low: begin
                if (w_rise) begin
                    w_publish    = 1'b1;
                    w_clear      = 1'b1;
                    w_state_next = c_st_high;
                end
            end
            default: begin
                w_state_next = c_st_settle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= '0;
            r_presc      <= '0;
            r_units      <= '0;
            r_on_hold    <= '0;
            r_on_period  <= '0;
            r_off_period <= '0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_state == c_st_settle) begin
                r_settle_cnt <= r_settle_cnt + c_sw'(1);
            end

            if (w_clear) begin
                r_presc <= c_presc_half;
                r_units <= '0;
                r_stuck <= 1'b0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
                r_units <= w_units_inc;
                r_stuck <= (w_units_inc == c_units_max);
            end

            if (w_latch_on) begin
                r_on_hold <= w_units_inc;
            end

            if (w_publish) begin
                r_on_period  <= r_on_hold;
                r_off_period <= w_units_inc;
                r_ovf        <= (r_on_hold == c_units_max) | (w_units_inc == c_units_max);
                r_done       <= 1'b1;
            end
        end
    end

    assign on_period  = r_on_period;
    assign off_period = r_off_period;
    assign done       = r_done;
    assign ovf        = r_ovf;
    assign stuck      = r_stuck;

endmodule
`default_nettype wire

// File: doc/square_wave_meas.md
Name: square_wave_meas

Overview:
- Receive-side counterpart of the programmable square wave generator: samples an asynchronous square wave and measures its high and low phase lengths in the same time unit the generator is programmed in (one unit = UNIT_CYCLES clocks, 100 ns at 10 ns clk).
- Publishes a matched on/off pair once per complete period (rise, fall, rise), with saturation and stuck-signal flags.
- Used for loopback checking of the generator and for measuring external PWM-like inputs.

Parameters:
- UNIT_CYCLES, 10, clock cycles per measurement unit; must be even and >= 2.
- W, 4, width of the measured period fields; same as the generator's on/off period width.
- SYNC_STAGES, 2, synchronizer flop count; must be >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- signal  input  1  asynchronous square wave under measurement.
- on_period  output  W  last measured high-phase length, in units.
- off_period  output  W  last measured low-phase length, in units.
- done  output  1  one-cycle pulse; on_period/off_period/ovf updated this cycle.
- ovf  output  1  set with done if either phase of that period saturated.
- stuck  output  1  level; current phase has reached saturation without an edge.

Behaviour:
- Reset (synchronous, active-high): on_period=0, off_period=0, done=0, ovf=0, stuck=0. Synchronizer flops = 0, counters = 0, state = SETTLE. Reset asserted mid-measurement discards the partial period; no done is produced for it.
- Input path:
  - signal passes through SYNC_STAGES flops, then a 1-flop edge detector.
  - rise = s & ~s_d; fall = ~s & s_d.
  - At most one edge per cycle.
- Phase length:
  - c = clock cycles between consecutive detected edges.
  - units = min(floor((c + UNIT_CYCLES/2) / UNIT_CYCLES), 2^W-1), i.e. rounded to the nearest unit.
  - Implement as a prescaler preloaded with UNIT_CYCLES/2 on each edge cycle, plus a saturating W-bit unit counter. No divider.
- FSM:
  - SETTLE: count SYNC_STAGES+1 cycles, ignoring edges (prevents a false edge from the reset values), then go to ARM.
  - ARM: falling edges ignored; on rise clear counters and go to HIGH. The unit counter runs so stuck can assert.
  - HIGH: on fall, latch units into on_hold, clear counters, go to LOW.
  - LOW: on rise:
    - on_period <= on_hold, off_period <= units, ovf <= on_sat | off_sat, done <= 1 for one cycle.
    - Clear counters; go to HIGH.
- Latency: done is high in the cycle after clock edge SYNC_STAGES+1 following the first clk edge that samples signal high. That is cycle 3 after sampling for SYNC_STAGES=2.
- Outputs are registered and hold their values until the next done.
- The first rise after reset starts a measurement only; the first done comes one full period later.
- stuck:
  - Asserts in the cycle the unit counter reaches 2^W-1 in ARM, HIGH or LOW.
  - Deasserts in the cycle after the next detected edge.
  - The counter saturates and does not wrap.
- Phases shorter than UNIT_CYCLES/2 cycles report 0 units and are otherwise handled normally.

Decomposition:
- Package square_wave_pkg:
  - FSM state encoding (SETTLE, ARM, HIGH, LOW).
  - Default UNIT_CYCLES and W constants, shared with the generator so loopback units match by construction.
- One sub-module, sync_edge_det: SYNC_STAGES synchronizer plus rise/fall detector, with synchronous reset.
- Counters and FSM stay in the top module.

Test Plan:
1. Generator loopback, on=3, off=1, UNIT_CYCLES=10 (30 clk high / 10 low) -> first done about 40 clk after the first rise; then done every 40 clk with on_period=3, off_period=1, ovf=0, stuck=0.
2. Switch to on=0, off=2 (signal constantly low) -> no further done; stuck=1 about 150 clk after the last edge; on_period/off_period hold 3/1.
3. Rounding: high 14 clk / low 15 clk -> on_period=1, off_period=2. High 4 clk -> on_period=0.
4. High 200 clk, low 20 clk -> stuck rises during high and clears one cycle after the fall; done with on_period=15, off_period=2, ovf=1. The next normal period gives ovf=0.
5. Reset pulsed mid-HIGH with signal held high -> all outputs 0, no false rise. The next fall is ignored; the first done comes one full period after the next real rise.
6. Signal high throughout reset release -> no edge detected in SETTLE/ARM until the signal falls then rises; measurement begins at that rise.
